input_conditioner: RTL
======================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable synchronized cycles required to accept a change (5 ms at 100 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 50000000, meaning cycles from the accepted press pulse to the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_RATE, default 20000000, meaning cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have parameter REPEAT_MASK, default 6'b001111, meaning per-button auto-repeat enable.
REQ-005 SHALL have port clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port btn_raw  input  6  raw asynchronous buttons: bit0 up, bit1 down, bit2 left, bit3 right, bit4 player_move, bit5 confirm_amount.
REQ-008 SHALL have port btn_level  output  6  debounced level per button.
REQ-009 SHALL have port btn_pulse  output  6  single-cycle press/repeat strobe per button, consumed by the game controller.

Function
REQ-010 SHALL pass each btn_raw bit through a two-flop synchronizer before any other logic.
REQ-011 SHALL keep one counter per button, cleared whenever the synchronized bit equals btn_level, incremented otherwise.
REQ-012 SHALL toggle btn_level[i] and clear the counter on the cycle the counter reaches DEBOUNCE_CYCLES-1.
REQ-013 SHALL make btn_level[i] rise exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples btn_raw[i] high, given btn_raw[i] stays high.
REQ-014 SHALL reject any raw pulse or bounce shorter than DEBOUNCE_CYCLES synchronized cycles, leaving btn_level and btn_pulse unchanged.
REQ-015 SHALL assert btn_pulse[i] for exactly one cycle, the same cycle btn_level[i] first reads 1.
REQ-016 SHALL never generate a pulse on release (btn_level falling).
REQ-017 SHALL implement a per-button FSM with states IDLE, HOLD and REPEAT.
REQ-018 SHALL move IDLE->HOLD on the press pulse, clearing the repeat counter.
REQ-019 SHALL, in HOLD with REPEAT_MASK[i]=1, emit a pulse and move to REPEAT when the counter reaches REPEAT_DELAY-1 since the press pulse, then clear the counter.
REQ-020 SHALL, in REPEAT, emit a pulse every REPEAT_RATE cycles while btn_level[i]=1.
REQ-021 SHALL, with REPEAT_MASK[i]=0, stay in HOLD with no further pulses until release.
REQ-022 SHALL return to IDLE from HOLD or REPEAT on the cycle btn_level[i] falls, clearing the counter; a pulse due that same cycle is suppressed.
REQ-023 SHALL handle buttons independently; simultaneous presses yield simultaneous pulses with no priority or masking.
REQ-024 SHALL size each counter as $clog2 of its maximum parameter, saturating rather than wrapping.

Reset
REQ-025 SHALL, while rst=1, clear synchronizers, counters, btn_level=6'b0 and btn_pulse=6'b0, and force all FSMs to IDLE, asynchronously.
REQ-026 SHALL emit no pulse on rst deassertion, even if a button is held; a held button is accepted after a full debounce window.
REQ-027 SHALL discard a press in progress when reset is asserted mid-debounce or mid-repeat, without emitting a pulse.

Structure
REQ-028 SHALL place NUM_BTN=6 and button index constants (BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_MOVE, BTN_CONFIRM) in shared battleship_pkg.
REQ-029 SHALL place the FSM state typedef (IDLE, HOLD, REPEAT) in battleship_pkg.
REQ-030 SHALL implement one channel in sub-module btn_channel (synchronizer, debounce, FSM), instantiated NUM_BTN times via generate.

Verification (bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-031 SHALL cover: bit0 high 3 cycles, then low -> btn_level and btn_pulse stay 0.
REQ-032 SHALL cover: bit1 held 40 cycles -> level rises at edge 6, pulse at 6, repeats at 26 and 34, then release -> no release pulse.
REQ-033 SHALL cover: bit5 held 60 cycles -> exactly one pulse (no repeat).
REQ-034 SHALL cover: bits 2 and 4 raised same cycle -> both pulses coincide, one cycle wide.
REQ-035 SHALL cover: bit3 toggling every 2 cycles for 20 cycles, then held high -> single pulse 6 edges after the final rise.
REQ-036 SHALL cover: rst asserted at cycle 15 of a held bit0 -> outputs 0 immediately, no pulse at rst release, new pulse 6 edges later.

Source files
------------

// File: rtl/battleship_pkg.sv
// -----------------------------------------------------------------------------
// battleship_pkg
// Shared definitions for the battleship front panel.
//   NUM_BTN         number of physical push buttons
//   BTN_*           bit index of each button inside the 6-bit button buses
//   rep_state_t     per-button auto-repeat state (IDLE, HOLD, REPEAT)
//   cnt_width()     width of a counter that must hold values 0..max_val-1
// -----------------------------------------------------------------------------
package battleship_pkg;

  localparam int NUM_BTN     = 6;

  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_LEFT    = 2;
  localparam int BTN_RIGHT   = 3;
  localparam int BTN_MOVE    = 4;
  localparam int BTN_CONFIRM = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // $clog2 of the largest count, never narrower than one bit so that a
  // parameter of 1 still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage : battleship_pkg

// File: rtl/btn_channel.sv
// -----------------------------------------------------------------------------
// btn_channel
// One button path: two-flop synchronizer, counting debouncer and an
// auto-repeat state machine that turns a debounced press into strobes.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive disagreeing synchronized cycles needed to
//                    flip the debounced level
//   REPEAT_DELAY     cycles from the press strobe to the first repeat strobe
//   REPEAT_RATE      cycles between later repeat strobes
//   REPEAT_EN        1 = auto-repeat enabled for this button
//
// Ports
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   raw    raw asynchronous button input
//   level  debounced button level
//   pulse  one-cycle strobe on press and on each auto-repeat
// -----------------------------------------------------------------------------
module btn_channel
  import battleship_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   REPEAT_DELAY    = 50000000,
  parameter int   REPEAT_RATE     = 20000000,
  parameter logic REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int DEB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = cnt_width(REP_MAX);

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [DEB_W-1:0] deb_cnt;
  logic [REP_W-1:0] rep_cnt;
  rep_state_t       state;

  logic mismatch;
  logic deb_done;
  logic press;
  logic release_now;

  // The debounced level flips on the cycle the counter has already seen
  // DEBOUNCE_CYCLES-1 disagreeing cycles and the current one still disagrees.
  assign mismatch    = sync_p1 ^ level;
  assign deb_done    = mismatch && (deb_cnt == DEB_LAST);
  assign press       = deb_done && !level;
  assign release_now = deb_done && level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      deb_cnt <= '0;
      level   <= 1'b0;
      rep_cnt <= '0;
      pulse   <= 1'b0;
      state   <= IDLE;
    end else begin
      // stage p0/p1: metastability synchronizer
      sync_p0 <= raw;
      sync_p1 <= sync_p0;

      // debounce: counter only runs while the input disagrees with level
      if (!mismatch) begin
        deb_cnt <= '0;
      end else if (deb_done) begin
        deb_cnt <= '0;
        level   <= ~level;
      end else if (deb_cnt != '1) begin
        deb_cnt <= deb_cnt + 1'b1;
      end

      // auto-repeat FSM; pulse defaults low so every strobe is one cycle
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          rep_cnt <= '0;
          if (press) begin
            pulse <= 1'b1;
            state <= HOLD;
          end
        end

        HOLD: begin
          // A release wins over a repeat falling due on the same cycle.
          if (release_now) begin
            state   <= IDLE;
            rep_cnt <= '0;
          end else if (REPEAT_EN && (rep_cnt == DELAY_LAST)) begin
            pulse   <= 1'b1;
            state   <= REPEAT;
            rep_cnt <= '0;
          end else if (rep_cnt != '1) begin
            // Saturates while a non-repeating button stays held.
            rep_cnt <= rep_cnt + 1'b1;
          end
        end

        REPEAT: begin
          if (release_now) begin
            state   <= IDLE;
            rep_cnt <= '0;
          end else if (rep_cnt == RATE_LAST) begin
            pulse   <= 1'b1;
            rep_cnt <= '0;
          end else if (rep_cnt != '1) begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          rep_cnt <= '0;
        end
      endcase
    end
  end

endmodule : btn_channel

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Conditions the six front-panel buttons of the battleship game: each raw
// button is synchronized, debounced and turned into a press/auto-repeat strobe
// for the game controller. Buttons are fully independent of each other.
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronized cycles to accept a change
//   REPEAT_DELAY     cycles from press strobe to first repeat strobe
//   REPEAT_RATE      cycles between subsequent repeat strobes
//   REPEAT_MASK      per-button auto-repeat enable
//
// Ports
//   clk        system clock (100 MHz), rising edge
//   rst        asynchronous active-high reset
//   btn_raw    raw buttons: up, down, left, right, player_move, confirm_amount
//   btn_level  debounced level per button
//   btn_pulse  single-cycle press/repeat strobe per button
// -----------------------------------------------------------------------------
module input_conditioner
  import battleship_pkg::*;
#(
  parameter int                 DEBOUNCE_CYCLES = 500000,
  parameter int                 REPEAT_DELAY    = 50000000,
  parameter int                 REPEAT_RATE     = 20000000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 6'b001111
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .pulse (btn_pulse[i])
    );
  end

endmodule : input_conditioner
